rename_free_list_ctrl: RTL and testbench
========================================

# rename_free_list_ctrl

Controller for the physical-register free list that feeds the front-end rename alias table. It hands out one free physical register ID per cycle to the rename stage. It reclaims the previous mapping of each retiring destination, and on a flush or syscall it rewinds allocation to the last committed point. It sits between the rename stage, which consumes IDs and produces the stall, and retirement, which returns IDs.

## Interface
Parameters:
- NUM_PHYS, 64: physical registers.
- NUM_ARCH, 34: architectural registers (32 GPR + HI/LO), mapped at reset.
- PREG_W, 6: physical ID width.
- FL_DEPTH, 32: free-list entries (power of two, ≥ NUM_PHYS−NUM_ARCH).

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-high.
- ALLOC_REQ  in  1  rename stage needs a destination ID this cycle.
- STALL_IN  in  1  downstream (RQ/IQ) stall; blocks allocation.
- ALLOC_VALID  out  1  a free ID is presented.
- ALLOC_ID  out  PREG_W  ID at head; 0 when ALLOC_VALID=0.
- STALL_OUT  out  1  rename must hold.
- RETIRE_VALID  in  1  an instruction retires this cycle.
- RETIRE_ALLOC  in  1  the retiring instruction had allocated a destination.
- RETIRE_OLD_ID  in  PREG_W  its previous mapping, to be freed.
- FLUSH  in  1  mispredict or SYS recovery.
- FREE_COUNT  out  PREG_W  entries currently allocatable.
- OVERFLOW_ERR  out  1  sticky; a push was dropped because the list was full.

## Operation
- Storage: circular buffer of FL_DEPTH × PREG_W. Pointers head (alloc), tail (free) and commit_head are each log2(FL_DEPTH)+1 bits, including a wrap bit.
- count = tail − head (mod 2·FL_DEPTH), range 0..FL_DEPTH.
- FSM states:
  - INIT: entered on reset. A counter i = 0..NUM_PHYS−NUM_ARCH−1 writes NUM_ARCH+i to mem[i], one entry per cycle. After the last write: head=commit_head=0, tail=NUM_PHYS−NUM_ARCH, go to RUN.
  - RUN: normal operation.
  - RECOVER: a single bubble cycle after FLUSH, then back to RUN.
- Allocation fires when ALLOC_REQ & ~STALL_IN & ALLOC_VALID; head advances by 1.
- ALLOC_VALID = (state==RUN) & (count≠0).
- Free fires when RETIRE_VALID & RETIRE_ALLOC in RUN or RECOVER: mem[tail] ← RETIRE_OLD_ID, tail+1, commit_head+1.
  - If count==FL_DEPTH, the push is dropped and OVERFLOW_ERR is set. commit_head still advances.
- FLUSH in RUN: head ← commit_head (the post-retire value if a retire occurs the same cycle), go to RECOVER. Allocation that cycle is suppressed.
- FLUSH in RECOVER repeats the rewind. FLUSH in INIT is ignored.
- Empty list with a same-cycle retire: no bypass. The freed ID becomes allocatable the next cycle.
- STALL_OUT = (state≠RUN) | FLUSH | (ALLOC_REQ & count==0).
- FREE_COUNT is count when state≠INIT, else 0.

## Timing
- Reset values: state=INIT, all pointers 0, ALLOC_VALID=0, ALLOC_ID=0, STALL_OUT=1, FREE_COUNT=0, OVERFLOW_ERR=0. Memory contents are not reset.
- INIT lasts NUM_PHYS−NUM_ARCH cycles (30). ALLOC_VALID rises on the following cycle.
- ALLOC_ID and ALLOC_VALID are combinational from registered state and memory only; they have no input-to-output path.
- STALL_OUT is combinational from ALLOC_REQ and FLUSH.
- Allocation throughput is 1 per cycle. A pushed ID is visible at head at the earliest one cycle after the push.
- FLUSH to first post-flush allocation: 2 cycles (flush edge, then the RECOVER edge).
- RESET asserted mid-INIT or mid-RUN returns to INIT and restarts the counter at 0.

## Structure
- Shared package rename_pkg: NUM_PHYS, NUM_ARCH, PREG_W, FL_DEPTH, and the state enum {INIT, RUN, RECOVER}.
- One sub-module, free_list_ram: FL_DEPTH × PREG_W, 1 synchronous write port, 1 asynchronous read port, no reset.
- Pointer, count and FSM logic live in rename_free_list_ctrl.

## Test plan
- Reset then idle 30 cycles → cycle 31: ALLOC_VALID=1, ALLOC_ID=34, FREE_COUNT=30, STALL_OUT=0.
- Hold ALLOC_REQ for 31 cycles after init → IDs 34..63 granted in order. Then FREE_COUNT=0, ALLOC_VALID=0, STALL_OUT=1.
- Empty list, retire OLD_ID=5 with ALLOC_REQ high → no grant that cycle; next cycle ALLOC_ID=5 is granted.
- Allocate 34, 35, 36; retire one with OLD_ID=7 together with FLUSH → next cycle STALL_OUT=1. The cycle after: ALLOC_ID=35, FREE_COUNT=30.
- ALLOC_REQ with STALL_IN=1 for 5 cycles → head, ALLOC_ID=34 and FREE_COUNT=30 unchanged.
- Assert RESET at INIT cycle 10 → 30 full INIT cycles follow before ALLOC_VALID=1. Then 3 retires with count 30 → third push dropped, OVERFLOW_ERR=1, FREE_COUNT=32.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared sizing and FSM state type for the rename free-list controller.
package rename_pkg;

  localparam int NUM_PHYS = 64;  // physical registers
  localparam int NUM_ARCH = 34;  // 32 GPR + HI/LO, mapped at reset
  localparam int PREG_W   = 6;   // physical register ID width
  localparam int FL_DEPTH = 32;  // free-list entries (power of two)

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RUN     = 2'd1,
    RECOVER = 2'd2
  } fl_state_e;

endpackage

// File: rtl/free_list_ram.sv
// Free-list storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the controller fills them in INIT.
module free_list_ram
  import rename_pkg::*;
#(
  parameter int DEPTH = FL_DEPTH,
  parameter int WIDTH = PREG_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             WE,
  input  logic [AW-1:0]    WADDR,
  input  logic [WIDTH-1:0] WDATA,
  input  logic [AW-1:0]    RADDR,
  output logic [WIDTH-1:0] RDATA
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Single write port, clocked.
  always_ff @(posedge CLK) begin
    if (WE) mem[WADDR] <= WDATA;
  end

  // Asynchronous read of the entry at the allocation head.
  always_comb begin
    RDATA = mem[RADDR];
  end

endmodule

// File: rtl/rename_free_list_ctrl.sv
// Physical-register free-list controller: hands out one free ID per cycle,
// reclaims retiring old mappings, and rewinds allocation on FLUSH.
module rename_free_list_ctrl #(
  parameter int NUM_PHYS = rename_pkg::NUM_PHYS,
  parameter int NUM_ARCH = rename_pkg::NUM_ARCH,
  parameter int PREG_W   = rename_pkg::PREG_W,
  parameter int FL_DEPTH = rename_pkg::FL_DEPTH
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ALLOC_REQ,
  input  logic              STALL_IN,
  output logic              ALLOC_VALID,
  output logic [PREG_W-1:0] ALLOC_ID,
  output logic              STALL_OUT,
  input  logic              RETIRE_VALID,
  input  logic              RETIRE_ALLOC,
  input  logic [PREG_W-1:0] RETIRE_OLD_ID,
  input  logic              FLUSH,
  output logic [PREG_W-1:0] FREE_COUNT,
  output logic              OVERFLOW_ERR
);

  import rename_pkg::*;

  localparam int PTR_W  = $clog2(FL_DEPTH) + 1;
  localparam int AW     = PTR_W - 1;
  localparam int INIT_N = NUM_PHYS - NUM_ARCH;

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_FULL  = PTR_W'(FL_DEPTH);
  localparam logic [PTR_W-1:0] INIT_LAST = PTR_W'(INIT_N - 1);
  localparam logic [PTR_W-1:0] INIT_TAIL = PTR_W'(INIT_N);

  fl_state_e state, state_nxt;

  logic [PTR_W-1:0]  head, tail, commit_head, commit_nxt;
  logic [PTR_W-1:0]  init_cnt, count;
  logic              overflow_q;
  logic              init_last, alloc_fire, retire_fire, list_full, push_ok;

  logic              ram_we;
  logic [AW-1:0]     ram_waddr, ram_raddr;
  logic [PREG_W-1:0] ram_wdata, ram_rdata;

  free_list_ram #(
    .DEPTH (FL_DEPTH),
    .WIDTH (PREG_W)
  ) u_ram (
    .CLK   (CLK),
    .WE    (ram_we),
    .WADDR (ram_waddr),
    .WDATA (ram_wdata),
    .RADDR (ram_raddr),
    .RDATA (ram_rdata)
  );

  // Occupancy, fire conditions and externally visible status.
  always_comb begin
    count        = tail - head;
    list_full    = (count == PTR_FULL);
    init_last    = (state == INIT) && (init_cnt == INIT_LAST);
    ALLOC_VALID  = (state == RUN) && (count != '0);
    ram_raddr    = head[AW-1:0];
    ALLOC_ID     = ALLOC_VALID ? ram_rdata : '0;
    alloc_fire   = ALLOC_REQ & ~STALL_IN & ALLOC_VALID & ~FLUSH;
    retire_fire  = RETIRE_VALID & RETIRE_ALLOC & (state != INIT);
    push_ok      = retire_fire & ~list_full;
    // A same-cycle retire moves the commit point before FLUSH rewinds to it.
    commit_nxt   = commit_head + (retire_fire ? PTR_ONE : '0);
    STALL_OUT    = (state != RUN) | FLUSH | (ALLOC_REQ & (count == '0));
    FREE_COUNT   = (state == INIT) ? '0 : PREG_W'(count);
    OVERFLOW_ERR = overflow_q;
  end

  // Write port is shared: the INIT fill sequence, otherwise retire pushes.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = tail[AW-1:0];
    ram_wdata = RETIRE_OLD_ID;
    if (state == INIT) begin
      ram_we    = 1'b1;
      ram_waddr = init_cnt[AW-1:0];
      ram_wdata = PREG_W'(NUM_ARCH) + PREG_W'(init_cnt);
    end else begin
      ram_we = push_ok;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= INIT;
    else       state <= state_nxt;
  end

  // FSM next-state: fill, run, one bubble after each flush.
  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT:    if (init_last) state_nxt = RUN;
      RUN:     if (FLUSH)     state_nxt = RECOVER;
      RECOVER: state_nxt = FLUSH ? RECOVER : RUN;
      default: state_nxt = INIT;
    endcase
  end

  // Pointer, init counter and sticky overflow updates.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      head        <= '0;
      tail        <= '0;
      commit_head <= '0;
      init_cnt    <= '0;
      overflow_q  <= 1'b0;
    end else if (state == INIT) begin
      if (init_last) begin
        init_cnt    <= '0;
        head        <= '0;
        commit_head <= '0;
        tail        <= INIT_TAIL;
      end else begin
        init_cnt <= init_cnt + PTR_ONE;
      end
    end else begin
      if (push_ok)                 tail       <= tail + PTR_ONE;
      if (retire_fire & list_full) overflow_q <= 1'b1;
      commit_head <= commit_nxt;
      if (FLUSH)           head <= commit_nxt;
      else if (alloc_fire) head <= head + PTR_ONE;
    end
  end

endmodule

// File: tb/tb_rename_free_list_ctrl.sv
// Directed bench for rename_free_list_ctrl with hand-computed expectations.
module tb_rename_free_list_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       ALLOC_REQ, STALL_IN, ALLOC_VALID, STALL_OUT;
  logic [5:0] ALLOC_ID, RETIRE_OLD_ID, FREE_COUNT;
  logic       RETIRE_VALID, RETIRE_ALLOC, FLUSH, OVERFLOW_ERR;

  int checks = 0;
  int errors = 0;

  rename_free_list_ctrl #(
    .NUM_PHYS (64),
    .NUM_ARCH (34),
    .PREG_W   (6),
    .FL_DEPTH (32)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .ALLOC_REQ     (ALLOC_REQ),
    .STALL_IN      (STALL_IN),
    .ALLOC_VALID   (ALLOC_VALID),
    .ALLOC_ID      (ALLOC_ID),
    .STALL_OUT     (STALL_OUT),
    .RETIRE_VALID  (RETIRE_VALID),
    .RETIRE_ALLOC  (RETIRE_ALLOC),
    .RETIRE_OLD_ID (RETIRE_OLD_ID),
    .FLUSH         (FLUSH),
    .FREE_COUNT    (FREE_COUNT),
    .OVERFLOW_ERR  (OVERFLOW_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ALLOC_REQ     = 1'b0;
    STALL_IN      = 1'b0;
    RETIRE_VALID  = 1'b0;
    RETIRE_ALLOC  = 1'b0;
    RETIRE_OLD_ID = '0;
    FLUSH         = 1'b0;
  endtask

  // Reset, release, then let the 30-cycle fill complete.
  task automatic reset_and_init();
    idle_inputs();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    repeat (30) tick();
  endtask

  initial begin
    idle_inputs();
    RESET = 1'b1;
    tick();
    tick();
    // Reset state
    chk("rst_valid", 32'(ALLOC_VALID), 0);
    chk("rst_id", 32'(ALLOC_ID), 0);
    chk("rst_stall", 32'(STALL_OUT), 1);
    chk("rst_count", 32'(FREE_COUNT), 0);
    chk("rst_ovf", 32'(OVERFLOW_ERR), 0);
    RESET = 1'b0;

    // Fill takes exactly 30 edges
    repeat (29) tick();
    chk("init29_valid", 32'(ALLOC_VALID), 0);
    chk("init29_stall", 32'(STALL_OUT), 1);
    chk("init29_count", 32'(FREE_COUNT), 0);
    tick();
    chk("init_valid", 32'(ALLOC_VALID), 1);
    chk("init_id", 32'(ALLOC_ID), 34);
    chk("init_count", 32'(FREE_COUNT), 30);
    chk("init_stall", 32'(STALL_OUT), 0);

    // STALL_IN blocks allocation for 5 cycles
    ALLOC_REQ = 1'b1;
    STALL_IN  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stallin_id", 32'(ALLOC_ID), 34);
      tick();
    end
    chk("stallin_id_after", 32'(ALLOC_ID), 34);
    chk("stallin_count", 32'(FREE_COUNT), 30);
    chk("stallin_stall", 32'(STALL_OUT), 0);

    // Drain: 34..63 in order, one per cycle
    STALL_IN = 1'b0;
    for (int k = 0; k < 30; k++) begin
      #1;
      chk("drain_valid", 32'(ALLOC_VALID), 1);
      chk("drain_id", 32'(ALLOC_ID), 32'(34 + k));
      tick();
    end
    chk("empty_valid", 32'(ALLOC_VALID), 0);
    chk("empty_id", 32'(ALLOC_ID), 0);
    chk("empty_count", 32'(FREE_COUNT), 0);
    chk("empty_stall", 32'(STALL_OUT), 1);

    // Retire into an empty list: no bypass, ID 5 granted next cycle
    RETIRE_VALID  = 1'b1;
    RETIRE_ALLOC  = 1'b1;
    RETIRE_OLD_ID = 6'd5;
    #1;
    chk("nobypass_valid", 32'(ALLOC_VALID), 0);
    chk("nobypass_stall", 32'(STALL_OUT), 1);
    tick();
    RETIRE_VALID = 1'b0;
    RETIRE_ALLOC = 1'b0;
    #1;
    chk("freed_valid", 32'(ALLOC_VALID), 1);
    chk("freed_id", 32'(ALLOC_ID), 5);
    chk("freed_count", 32'(FREE_COUNT), 1);
    chk("freed_stall", 32'(STALL_OUT), 0);
    tick();
    chk("regrant_count", 32'(FREE_COUNT), 0);
    // Retire without a destination frees nothing
    ALLOC_REQ     = 1'b0;
    RETIRE_VALID  = 1'b1;
    RETIRE_ALLOC  = 1'b0;
    RETIRE_OLD_ID = 6'd9;
    tick();
    RETIRE_VALID = 1'b0;
    #1;
    chk("noalloc_retire_count", 32'(FREE_COUNT), 0);
    chk("noalloc_retire_valid", 32'(ALLOC_VALID), 0);

    // Mid-RUN reset, then flush rewinds to the commit point
    reset_and_init();
    chk("reinit_id", 32'(ALLOC_ID), 34);
    ALLOC_REQ = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("pre_flush_id", 32'(ALLOC_ID), 32'(34 + k));
      tick();
    end
    RETIRE_VALID  = 1'b1;
    RETIRE_ALLOC  = 1'b1;
    RETIRE_OLD_ID = 6'd7;
    FLUSH         = 1'b1;
    #1;
    chk("flush_stall", 32'(STALL_OUT), 1);
    chk("flush_head_id", 32'(ALLOC_ID), 37);
    tick();
    idle_inputs();
    #1;
    chk("recover_stall", 32'(STALL_OUT), 1);
    chk("recover_valid", 32'(ALLOC_VALID), 0);
    chk("recover_id", 32'(ALLOC_ID), 0);
    tick();
    chk("post_flush_valid", 32'(ALLOC_VALID), 1);
    chk("post_flush_id", 32'(ALLOC_ID), 35);
    chk("post_flush_count", 32'(FREE_COUNT), 30);

    // Reset in the middle of INIT restarts the fill counter
    idle_inputs();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    repeat (10) tick();
    RESET = 1'b1;
    #1;
    chk("midinit_rst_count", 32'(FREE_COUNT), 0);
    chk("midinit_rst_stall", 32'(STALL_OUT), 1);
    tick();
    RESET = 1'b0;
    repeat (29) tick();
    chk("midinit29_valid", 32'(ALLOC_VALID), 0);
    tick();
    chk("midinit30_valid", 32'(ALLOC_VALID), 1);
    chk("midinit30_id", 32'(ALLOC_ID), 34);
    chk("midinit30_count", 32'(FREE_COUNT), 30);

    // Three retires at count 30: third push dropped, overflow sticky
    RETIRE_VALID = 1'b1;
    RETIRE_ALLOC = 1'b1;
    RETIRE_OLD_ID = 6'd1;
    tick();
    chk("ovf1_count", 32'(FREE_COUNT), 31);
    chk("ovf1_err", 32'(OVERFLOW_ERR), 0);
    RETIRE_OLD_ID = 6'd2;
    tick();
    chk("ovf2_count", 32'(FREE_COUNT), 32);
    chk("ovf2_err", 32'(OVERFLOW_ERR), 0);
    RETIRE_OLD_ID = 6'd3;
    tick();
    chk("ovf3_count", 32'(FREE_COUNT), 32);
    chk("ovf3_err", 32'(OVERFLOW_ERR), 1);

    // Drain the full list: 34..63 then the two pushed IDs 1, 2
    idle_inputs();
    ALLOC_REQ = 1'b1;
    for (int k = 0; k < 32; k++) begin
      #1;
      chk("full_drain_valid", 32'(ALLOC_VALID), 1);
      chk("full_drain_id", 32'(ALLOC_ID), (k < 30) ? 32'(34 + k) : 32'(k - 29));
      tick();
    end
    chk("full_drain_empty", 32'(ALLOC_VALID), 0);
    chk("full_drain_count", 32'(FREE_COUNT), 0);
    chk("ovf_sticky", 32'(OVERFLOW_ERR), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
